// File: rtl/memory_stage_if.sv
// Shared pipeline bundle types and the data-bus interface used by memory_stage.
// The stage drives requests through the master modport, and the memory side answers through the slave modport.
package memory_stage_pkg;

    typedef struct packed {
        logic       MemR;
        logic       MemW;
        logic [1:0] msize;
        logic       LoadU;
    } ctl_t;

    typedef struct packed {
        logic [63:0] pc;
        ctl_t        ctl;
        logic [63:0] alu;
        logic [63:0] rs2;
        logic        valid;
    } execute_data_t;

    typedef struct packed {
        logic [63:0] pc;
        ctl_t        ctl;
        logic [63:0] alu;
        logic [63:0] rd;
        logic        valid;
    } memory_data_t;

endpackage

interface memory_stage_if #(
    parameter int AW = 64,
    parameter int DW = 64
);
    logic          dreq_valid;
    logic [AW-1:0] dreq_addr;
    logic [2:0]    dreq_size;
    logic [7:0]    dreq_strobe;
    logic [DW-1:0] dreq_data;
    logic          dresp_data_ok;
    logic [DW-1:0] dresp_data;

    modport master (
        output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        input  dresp_data_ok, dresp_data
    );

    modport slave (
        input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        output dresp_data_ok, dresp_data
    );
endinterface

// File: rtl/memory_stage.sv
// Memory pipeline stage: issues one data-bus transaction per load or store and stalls upstream until the transaction completes.
// Non-memory and misaligned instructions pass straight through in the same cycle.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int AW = 64,
    parameter int DW = 64
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  execute_data_t         dataE,
    input  logic                  flush,
    output memory_data_t          dataM_nxt,
    output logic                  stallM,
    output logic                  misalign,
    memory_stage_if.master        bus
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

    state_t        stateR, stateNxt;
    logic          reqValidR;
    logic [AW-1:0] reqAddrR;
    logic [1:0]    reqSizeR;
    logic [7:0]    reqStrobeR;
    logic [DW-1:0] reqDataR;
    logic          reqLoadR;
    logic          reqLoadUR;
    logic [DW-1:0] capturedR;
    logic [2:0]    sizeMask;
    logic          memOp;
    logic          startReq;

    function automatic logic [7:0] laneStrobe(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] s;
        case (size)
            2'd0:    s = 8'h01 << off;
            2'd1:    s = 8'h03 << off;
            2'd2:    s = 8'h0F << off;
            2'd3:    s = 8'hFF;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    function automatic logic [63:0] loadExtract(input logic [63:0] raw, input logic [2:0] off,
                                                input logic [1:0] size, input logic zext);
        logic [63:0] tmp;
        logic [63:0] r;
        tmp = raw >> {off, 3'b000};
        case (size)
            2'd0:    r = zext ? {56'd0, tmp[7:0]}  : {{56{tmp[7]}},  tmp[7:0]};
            2'd1:    r = zext ? {48'd0, tmp[15:0]} : {{48{tmp[15]}}, tmp[15:0]};
            2'd2:    r = zext ? {32'd0, tmp[31:0]} : {{32{tmp[31]}}, tmp[31:0]};
            2'd3:    r = tmp;
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    // Low address bits that must be zero for a naturally aligned access of this size.
    assign sizeMask = ~(3'b111 << dataE.ctl.msize);
    assign misalign = dataE.valid & (dataE.ctl.MemR | dataE.ctl.MemW) & (|(dataE.alu[2:0] & sizeMask));
    assign memOp    = dataE.valid & (dataE.ctl.MemR | dataE.ctl.MemW) & ~misalign;
    assign startReq = (stateR == IDLE) & memOp & ~flush;

    assign bus.dreq_valid  = reqValidR;
    assign bus.dreq_addr   = reqAddrR;
    assign bus.dreq_size   = {1'b0, reqSizeR};
    assign bus.dreq_strobe = reqStrobeR;
    assign bus.dreq_data   = reqDataR;

    // State register plus the request and response capture registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stateR     <= IDLE;
            reqValidR  <= 1'b0;
            reqAddrR   <= '0;
            reqSizeR   <= 2'd0;
            reqStrobeR <= 8'h00;
            reqDataR   <= '0;
            reqLoadR   <= 1'b0;
            reqLoadUR  <= 1'b0;
            capturedR  <= '0;
        end else begin
            stateR <= stateNxt;
            if (startReq) begin
                reqValidR  <= 1'b1;
                reqAddrR   <= dataE.alu[AW-1:0];
                reqSizeR   <= dataE.ctl.msize;
                reqStrobeR <= dataE.ctl.MemW ? laneStrobe(dataE.ctl.msize, dataE.alu[2:0]) : 8'h00;
                reqDataR   <= dataE.rs2[DW-1:0] << {dataE.alu[2:0], 3'b000};
                reqLoadR   <= dataE.ctl.MemR;
                reqLoadUR  <= dataE.ctl.LoadU;
            end else if ((stateR == REQ) && bus.dresp_data_ok) begin
                reqValidR <= 1'b0;
                capturedR <= bus.dresp_data;
            end else begin
                reqValidR <= reqValidR;
            end
        end
    end

    // Next state, stall and the outgoing bundle; a stalled stage emits a bubble.
    always_comb begin
        stateNxt        = stateR;
        stallM          = 1'b0;
        dataM_nxt.pc    = dataE.pc;
        dataM_nxt.ctl   = dataE.ctl;
        dataM_nxt.alu   = dataE.alu;
        dataM_nxt.rd    = dataE.alu;
        dataM_nxt.valid = dataE.valid;
        case (stateR)
            IDLE: begin
                if (flush) begin
                    dataM_nxt.valid = 1'b0;
                end else if (memOp) begin
                    stallM          = 1'b1;
                    dataM_nxt.valid = 1'b0;
                    stateNxt        = REQ;
                end else if (misalign) begin
                    dataM_nxt.rd = 64'd0;
                end else begin
                    stateNxt = IDLE;
                end
            end
            REQ: begin
                stallM          = 1'b1;
                dataM_nxt.valid = 1'b0;
                if (bus.dresp_data_ok) begin
                    stateNxt = DONE;
                end else begin
                    stateNxt = REQ;
                end
            end
            DONE: begin
                dataM_nxt.valid = 1'b1;
                dataM_nxt.rd    = reqLoadR ? loadExtract(capturedR, reqAddrR[2:0], reqSizeR, reqLoadUR) : 64'd0;
                stateNxt        = IDLE;
            end
            default: begin
                stateNxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: pass-through, loads, stores, misalignment, flush and reset during a request.
module tb_memory_stage;
    import memory_stage_pkg::*;

    logic          clk;
    logic          resetn;
    execute_data_t dataE;
    logic          flush;
    memory_data_t  dataM_nxt;
    logic          stallM;
    logic          misalign;

    int            nPass;
    int            nTotal;
    logic [2:0]    seenSize;
    logic [7:0]    seenStrobe;
    logic [63:0]   seenData;
    logic [63:0]   seenAddr;
    int            stalls;
    logic [63:0]   rdOut;
    logic          vOut;
    int            sawReq;

    memory_stage_if #(.AW(64), .DW(64)) bus ();

    memory_stage #(.AW(64), .DW(64)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .dataE     (dataE),
        .flush     (flush),
        .dataM_nxt (dataM_nxt),
        .stallM    (stallM),
        .misalign  (misalign),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nTotal++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            nPass++;
        end
    endtask

    task automatic setE(input logic v, input logic r, input logic w, input logic [1:0] sz,
                        input logic u, input logic [63:0] alu, input logic [63:0] rs2);
        dataE.pc        = 64'h400;
        dataE.valid     = v;
        dataE.ctl.MemR  = r;
        dataE.ctl.MemW  = w;
        dataE.ctl.msize = sz;
        dataE.ctl.LoadU = u;
        dataE.alu       = alu;
        dataE.rs2       = rs2;
    endtask

    // Runs one memory op already on dataE; answers with data_ok in the delay-th REQ cycle.
    task automatic runMem(input int delay, input logic [63:0] rdata);
        int  reqCyc;
        bit  done;
        reqCyc = 0;
        done   = 1'b0;
        stalls = 0;
        rdOut  = 64'hDEAD;
        vOut   = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            bus.dresp_data_ok = 1'b0;
            if (!stallM) begin
                done  = 1'b1;
                rdOut = dataM_nxt.rd;
                vOut  = dataM_nxt.valid;
            end else begin
                stalls++;
                if (bus.dreq_valid) begin
                    reqCyc++;
                    seenSize   = bus.dreq_size;
                    seenStrobe = bus.dreq_strobe;
                    seenData   = bus.dreq_data;
                    seenAddr   = bus.dreq_addr;
                    if (reqCyc == delay) begin
                        bus.dresp_data_ok = 1'b1;
                        bus.dresp_data    = rdata;
                    end
                end
            end
        end
        if (!done) chk("timeout", 64'd0, 64'd1);
    endtask

    task automatic nextInstr();
        @(posedge clk);
        #1;
        setE(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'd0);
        flush = 1'b0;
    endtask

    initial begin
        nPass  = 0;
        nTotal = 0;
        resetn = 1'b0;
        flush  = 1'b0;
        bus.dresp_data_ok = 1'b0;
        bus.dresp_data    = 64'd0;
        setE(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'd0);
        #12;
        chk("rst_dreq_valid", {63'd0, bus.dreq_valid}, 64'd0);
        chk("rst_stall", {63'd0, stallM}, 64'd0);
        chk("rst_addr", bus.dreq_addr, 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        // ALU pass-through
        @(posedge clk); #1;
        setE(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 64'h1234, 64'd0);
        #1;
        chk("alu_rd", dataM_nxt.rd, 64'h1234);
        chk("alu_valid", {63'd0, dataM_nxt.valid}, 64'd1);
        chk("alu_stall", {63'd0, stallM}, 64'd0);
        sawReq = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.dreq_valid) sawReq++;
        end
        chk("alu_no_req", sawReq, 0);

        // Load word signed, data_ok on the third REQ cycle
        nextInstr();
        setE(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 64'h80000004, 64'd0);
        runMem(3, 64'h8765432100000000);
        chk("lw_stalls", stalls, 4);
        chk("lw_rd", rdOut, 64'hFFFFFFFF87654321);
        chk("lw_valid", {63'd0, vOut}, 64'd1);
        chk("lw_size", {61'd0, seenSize}, 64'd2);
        chk("lw_addr", seenAddr, 64'h80000004);
        chk("lw_strobe", {56'd0, seenStrobe}, 64'd0);

        // Store byte at offset 3
        nextInstr();
        setE(1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 64'h1003, 64'hAB);
        runMem(1, 64'hFFFFFFFFFFFFFFFF);
        chk("sb_stalls", stalls, 2);
        chk("sb_strobe", {56'd0, seenStrobe}, 64'h08);
        chk("sb_data", seenData, 64'hAB000000);
        chk("sb_size", {61'd0, seenSize}, 64'd0);
        chk("sb_rd", rdOut, 64'd0);

        // Load half unsigned at offset 6
        nextInstr();
        setE(1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 64'h2006, 64'd0);
        runMem(2, 64'hBEEF000000000000);
        chk("lhu_rd", rdOut, 64'h000000000000BEEF);
        chk("lhu_stalls", stalls, 3);

        // Load byte signed at offset 5
        nextInstr();
        setE(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 64'h3005, 64'd0);
        runMem(1, 64'h0000_9A00_0000_0000);
        chk("lb_rd", rdOut, 64'hFFFFFFFFFFFFFF9A);

        // Store half at offset 2: strobe and lane shift
        nextInstr();
        setE(1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 64'h4002, 64'h1122);
        runMem(1, 64'd0);
        chk("sh_strobe", {56'd0, seenStrobe}, 64'h0C);
        chk("sh_data", seenData, 64'h11220000);

        // Misaligned word load
        nextInstr();
        setE(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 64'h1002, 64'd0);
        #1;
        chk("mis_flag", {63'd0, misalign}, 64'd1);
        chk("mis_stall", {63'd0, stallM}, 64'd0);
        chk("mis_valid", {63'd0, dataM_nxt.valid}, 64'd1);
        chk("mis_rd", dataM_nxt.rd, 64'd0);
        sawReq = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.dreq_valid) sawReq++;
        end
        chk("mis_no_req", sawReq, 0);

        // Flush in IDLE suppresses the request
        nextInstr();
        setE(1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 64'h5000, 64'd0);
        flush = 1'b1;
        #1;
        chk("flush_stall", {63'd0, stallM}, 64'd0);
        chk("flush_valid", {63'd0, dataM_nxt.valid}, 64'd0);
        @(negedge clk);
        chk("flush_no_req", {63'd0, bus.dreq_valid}, 64'd0);

        // Reset during REQ, then a normal dword load
        nextInstr();
        setE(1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 64'h6000, 64'd0);
        @(negedge clk);
        @(negedge clk);
        chk("mid_req_valid", {63'd0, bus.dreq_valid}, 64'd1);
        #1;
        resetn = 1'b0;
        #1;
        chk("rst_async_drop", {63'd0, bus.dreq_valid}, 64'd0);
        setE(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        setE(1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 64'h7008, 64'd0);
        runMem(1, 64'h0123456789ABCDEF);
        chk("post_rst_rd", rdOut, 64'h0123456789ABCDEF);
        chk("post_rst_stalls", stalls, 2);
        nextInstr();

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule
